snn_spike_readout: RTL and testbench

Downstream readout stage for the `snn` core inside `user_project_wrapper`. Captures output-spike events (neuron index plus timestep) from the core into a small FIFO and exposes them to the management SoC as a Wishbone slave. Raises an interrupt when the FIFO fill level reaches a programmable threshold. Overflow is counted, never silent.

---
 rtl/snn_spike_readout_pkg.sv | 37 +++
 rtl/snn_spike_readout_if.sv | 21 ++
 rtl/snn_spike_readout_fifo.sv | 53 +++++
 rtl/snn_spike_readout.sv | 143 ++++++++++++++
 tb/tb_snn_spike_readout.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_spike_readout_pkg.sv
// Shared definitions for the spike readout block: register map, field
// positions, the spike event record and the threshold helper.
package snn_pkg;

    localparam int DEF_NEURON_W = 6;
    localparam int DEF_TS_W     = 8;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int DATA_VALID_BIT = 31;
    localparam int DATA_TS_LSB    = 8;
    localparam int DATA_IDX_LSB   = 0;

    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_DROP_LSB  = 16;

    localparam int CTRL_CAP_BIT   = 0;
    localparam int CTRL_IRQ_BIT   = 1;
    localparam int CTRL_FLUSH_BIT = 2;
    localparam int CTRL_THR_LSB   = 8;
    localparam int THR_W          = 5;

    typedef struct packed {
        logic [DEF_TS_W-1:0]     timestep;
        logic [DEF_NEURON_W-1:0] index;
    } spike_evt_t;

    // A zero threshold is treated as one so an enabled irq never fires on an empty FIFO.
    function automatic logic [THR_W-1:0] eff_threshold(input logic [THR_W-1:0] thr);
        return (thr == {THR_W{1'b0}}) ? {{(THR_W-1){1'b0}}, 1'b1} : thr;
    endfunction

endpackage

// File: rtl/snn_spike_readout_if.sv
// Wishbone classic slave bus between the management SoC and the readout block.
interface snn_spike_readout_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/snn_spike_readout_fifo.sv
// Synchronous FIFO with extra-MSB pointers; flush resets both pointers and
// overrides any push or pop in the same cycle.
module snn_sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count = wr_ptr_r - rd_ptr_r;
    assign dout  = mem[rd_ptr_r[AW-1:0]];

    // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
    assign do_pop_s  = pop & ~empty & ~flush;
    assign do_push_s = push & (~full | do_pop_s) & ~flush;

    // Pointer update with flush priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (do_push_s) mem[wr_ptr_r[AW-1:0]] <= din;
    end
endmodule

// File: rtl/snn_spike_readout.sv
// Spike readout: captures snn output spikes into a FIFO and serves them,
// plus status/control, over a Wishbone slave with a threshold interrupt.
module snn_spike_readout #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0100,
    parameter int          NEURON_W  = snn_pkg::DEF_NEURON_W,
    parameter int          TS_W      = snn_pkg::DEF_TS_W,
    parameter int          DEPTH     = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                spike_valid_i,
    input  logic [NEURON_W-1:0] spike_idx_i,
    input  logic [TS_W-1:0]     timestep_i,
    snn_spike_readout_if.slave  wb,
    output logic                irq_o
);
    import snn_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = TS_W + NEURON_W;

    logic              ack_r;
    logic [31:0]       dat_r;
    logic              irq_r;
    logic              capture_en_r;
    logic              irq_en_r;
    logic [THR_W-1:0]  threshold_r;
    logic [15:0]       drop_count_r;

    logic              hit_s;
    logic              access_s;
    logic              rd_s;
    logic              wr_s;
    logic [1:0]        offset_s;
    logic              pop_s;
    logic              push_s;
    logic              flush_s;
    logic              ctrl_wr_s;
    logic              drop_clr_s;
    logic              drop_s;
    logic              irq_next_s;
    logic [EW-1:0]     head_s;
    logic              full_s;
    logic              empty_s;
    logic [CW-1:0]     count_s;
    logic [31:0]       rdata_s;
    logic              unused_bits;

    // Side effects happen on the edge that raises ack, so a held request cannot re-trigger them.
    assign hit_s      = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign access_s   = hit_s & ~ack_r;
    assign offset_s   = wb.wbs_adr_i[3:2];
    assign rd_s       = access_s & ~wb.wbs_we_i;
    assign wr_s       = access_s & wb.wbs_we_i;
    assign pop_s      = rd_s & (offset_s == REG_DATA) & ~empty_s;
    assign ctrl_wr_s  = wr_s & (offset_s == REG_CTRL);
    assign flush_s    = ctrl_wr_s & wb.wbs_sel_i[0] & wb.wbs_dat_i[CTRL_FLUSH_BIT];
    assign drop_clr_s = wr_s & (offset_s == REG_STATUS);
    assign push_s     = spike_valid_i & capture_en_r;
    assign drop_s     = push_s & full_s & ~pop_s & ~flush_s;
    assign irq_next_s = irq_en_r & (count_s != {CW{1'b0}})
                      & (32'(count_s) >= 32'(eff_threshold(threshold_r)));

    assign unused_bits = ^{wb.wbs_dat_i[31:13], wb.wbs_dat_i[7:3],
                           wb.wbs_sel_i[3:2], wb.wbs_adr_i[1:0]};

    snn_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   ({timestep_i, spike_idx_i}),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Read data multiplexer.
    always_comb begin
        rdata_s = 32'd0;
        case (offset_s)
            REG_DATA: begin
                if (!empty_s) begin
                    rdata_s[DATA_VALID_BIT]             = 1'b1;
                    rdata_s[DATA_TS_LSB +: TS_W]        = head_s[NEURON_W +: TS_W];
                    rdata_s[DATA_IDX_LSB +: NEURON_W]   = head_s[NEURON_W-1:0];
                end else begin
                    rdata_s = 32'd0;
                end
            end
            REG_STATUS: begin
                rdata_s[STAT_COUNT_LSB +: CW] = count_s;
                rdata_s[STAT_EMPTY_BIT]       = empty_s;
                rdata_s[STAT_FULL_BIT]        = full_s;
                rdata_s[STAT_DROP_LSB +: 16]  = drop_count_r;
            end
            REG_CTRL: begin
                rdata_s[CTRL_CAP_BIT]             = capture_en_r;
                rdata_s[CTRL_IRQ_BIT]             = irq_en_r;
                rdata_s[CTRL_THR_LSB +: THR_W]    = threshold_r;
            end
            default: rdata_s = 32'd0;
        endcase
    end

    // Bus response, control/drop registers and interrupt.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            ack_r        <= 1'b0;
            dat_r        <= 32'd0;
            irq_r        <= 1'b0;
            capture_en_r <= 1'b0;
            irq_en_r     <= 1'b0;
            threshold_r  <= {THR_W{1'b0}};
            drop_count_r <= 16'd0;
        end else begin
            ack_r <= access_s;
            dat_r <= rd_s ? rdata_s : 32'd0;
            irq_r <= irq_next_s;
            if (ctrl_wr_s) begin
                if (wb.wbs_sel_i[0]) begin
                    capture_en_r <= wb.wbs_dat_i[CTRL_CAP_BIT];
                    irq_en_r     <= wb.wbs_dat_i[CTRL_IRQ_BIT];
                end
                if (wb.wbs_sel_i[1]) threshold_r <= wb.wbs_dat_i[CTRL_THR_LSB +: THR_W];
            end
            if (drop_clr_s) begin
                drop_count_r <= 16'd0;
            end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    assign wb.wbs_ack_o = ack_r;
    assign wb.wbs_dat_o = dat_r;
    assign irq_o        = irq_r;
endmodule

// File: tb/tb_snn_spike_readout.sv
// Directed bench for snn_spike_readout: a queue-based reference model checked
// every cycle, plus hand-computed register readbacks.
module tb_snn_spike_readout;
    import snn_pkg::*;

    localparam logic [31:0] BASE  = 32'h3000_0100;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spike_valid;
    logic [5:0]  spike_idx;
    logic [7:0]  spike_ts;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    snn_spike_readout_if wb();

    snn_spike_readout #(
        .ADDR_BASE (BASE),
        .NEURON_W  (6),
        .TS_W      (8),
        .DEPTH     (DEPTH)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst_n),
        .spike_valid_i (spike_valid),
        .spike_idx_i   (spike_idx),
        .timestep_i    (spike_ts),
        .wb            (wb),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    spike_evt_t  q[$];
    spike_evt_t  m_evt;
    bit          m_ok = 1'b0;
    bit          m_cap, m_irqen, m_cap_old, m_req, m_acc, m_flush, m_clr, m_irq_next;
    int          m_thr, m_drop, m_off;
    logic [31:0] m_rd;
    logic        exp_ack, exp_irq;
    logic [31:0] exp_dat;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cap = 1'b0; m_irqen = 1'b0; m_thr = 0; m_drop = 0;
            exp_ack = 1'b0; exp_dat = 32'h0; exp_irq = 1'b0;
            m_ok = 1'b1;
        end else begin
            m_req = wb.wbs_cyc_i && wb.wbs_stb_i && (wb.wbs_adr_i[31:4] == BASE[31:4]);
            m_acc = m_req && !exp_ack;
            m_off = int'(wb.wbs_adr_i[3:2]) * 4;
            m_irq_next = m_irqen && (q.size() > 0) && (q.size() >= ((m_thr == 0) ? 1 : m_thr));
            m_cap_old = m_cap;
            m_flush = 1'b0;
            m_clr = 1'b0;
            m_rd = 32'h0;
            if (m_acc && !wb.wbs_we_i) begin
                case (m_off)
                    0: if (q.size() > 0) begin
                           m_evt = q.pop_front();
                           m_rd = 32'h8000_0000 | (32'(m_evt.timestep) << 8) | 32'(m_evt.index);
                       end
                    4: m_rd = 32'(q.size()) | ((q.size() == 0) ? 32'h100 : 32'h0)
                            | ((q.size() == DEPTH) ? 32'h200 : 32'h0) | (32'(m_drop) << 16);
                    8: m_rd = 32'(m_cap) | (32'(m_irqen) << 1) | (32'(m_thr) << 8);
                    default: m_rd = 32'h0;
                endcase
            end
            if (m_acc && wb.wbs_we_i) begin
                if (m_off == 8) begin
                    if (wb.wbs_sel_i[0]) begin
                        m_cap = wb.wbs_dat_i[0];
                        m_irqen = wb.wbs_dat_i[1];
                        m_flush = wb.wbs_dat_i[2];
                    end
                    if (wb.wbs_sel_i[1]) m_thr = int'(wb.wbs_dat_i[12:8]);
                end else if (m_off == 4) begin
                    m_clr = 1'b1;
                end
            end
            if (m_flush) begin
                q.delete();
            end else if (spike_valid && m_cap_old) begin
                if (q.size() < DEPTH) begin
                    m_evt.timestep = spike_ts;
                    m_evt.index = spike_idx;
                    q.push_back(m_evt);
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            if (m_clr) m_drop = 0;
            exp_ack = m_acc;
            exp_dat = m_rd;
            exp_irq = m_irq_next;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_ok) begin
            check("ack", 32'(wb.wbs_ack_o), 32'(exp_ack));
            check("dat_o", wb.wbs_dat_o, exp_dat);
            check("irq", 32'(irq), 32'(exp_irq));
        end
    end

    task automatic access(input bit we, input logic [3:0] off, input logic [31:0] d,
                          input logic [3:0] sel, input bit spk, input logic [5:0] idx,
                          input logic [7:0] ts, output logic [31:0] rdata);
        int n;
        @(posedge clk); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = BASE + 32'(off); wb.wbs_dat_i = d; wb.wbs_sel_i = sel;
        if (spk) begin
            spike_valid = 1'b1; spike_idx = idx; spike_ts = ts;
        end
        @(posedge clk); #1;
        spike_valid = 1'b0;
        n = 0;
        rdata = 32'h0;
        while (!wb.wbs_ack_o && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (wb.wbs_ack_o) begin
            rdata = wb.wbs_dat_o;
        end else begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout: got no ack expected ack for offset %0h", off);
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] rdata);
        access(1'b0, off, 32'h0, 4'hF, 1'b0, 6'd0, 8'd0, rdata);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] dummy;
        access(1'b1, off, d, sel, 1'b0, 6'd0, 8'd0, dummy);
    endtask

    task automatic spike(input logic [5:0] idx, input logic [7:0] ts);
        @(posedge clk); #1;
        spike_valid = 1'b1; spike_idx = idx; spike_ts = ts;
        @(posedge clk); #1;
        spike_valid = 1'b0;
    endtask

    logic [31:0] r;
    int acks;

    initial begin
        rst_n = 1'b0; spike_valid = 1'b0; spike_idx = 6'd0; spike_ts = 8'd0;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset defaults
        rd(4'h8, r); check("reset_ctrl", r, 32'h0000_0000);
        rd(4'h4, r); check("reset_status", r, 32'h0000_0100);
        check("reset_irq", 32'(irq), 32'h0);

        // Single event
        wr(4'h8, 32'h0000_0001, 4'hF);
        spike(6'd5, 8'h2A);
        rd(4'h0, r); check("single_data", r, 32'h8000_2A05);
        rd(4'h0, r); check("empty_data", r, 32'h0000_0000);
        rd(4'h4, r); check("single_status", r, 32'h0000_0100);

        // Overflow: 20 back-to-back spikes
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            spike_valid = 1'b1; spike_idx = 6'(i); spike_ts = 8'(8'h10 + i);
            @(posedge clk); #1;
        end
        spike_valid = 1'b0;
        rd(4'h4, r); check("overflow_status", r, 32'h0004_0210);

        // Full FIFO, pop and push together
        access(1'b0, 4'h0, 32'h0, 4'hF, 1'b1, 6'd63, 8'hEE, r);
        check("full_pushpop_data", r, 32'h8000_1000);
        rd(4'h4, r); check("full_pushpop_status", r, 32'h0004_0210);
        for (int i = 1; i < 16; i++) begin
            rd(4'h0, r);
            check("drain_order", r, 32'h8000_0000 | ((32'h10 + 32'(i)) << 8) | 32'(i));
        end
        rd(4'h0, r); check("drain_last", r, 32'h8000_EE3F);
        rd(4'h0, r); check("drain_empty", r, 32'h0000_0000);
        rd(4'h4, r); check("drain_status", r, 32'h0004_0100);

        // Interrupt threshold 4
        wr(4'h8, 32'h0000_0403, 4'hF);
        spike(6'd10, 8'h30);
        spike(6'd11, 8'h31);
        spike(6'd12, 8'h32);
        check("irq_below_thr", 32'(irq), 32'h0);
        spike(6'd13, 8'h33);
        check("irq_lag", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("irq_rise", 32'(irq), 32'h1);
        rd(4'h0, r); check("irq_pop_data", r, 32'h8000_300A);
        @(posedge clk); #1;
        check("irq_fall", 32'(irq), 32'h0);
        rd(4'h4, r); check("irq_status", r, 32'h0004_0003);

        // Flush wins over a simultaneous push
        access(1'b1, 4'h8, 32'h0000_0407, 4'hF, 1'b1, 6'd20, 8'h40, r);
        rd(4'h4, r); check("flush_status", r, 32'h0004_0100);
        rd(4'h8, r); check("flush_ctrl_readback", r, 32'h0000_0403);
        wr(4'h4, 32'h0, 4'hF);
        rd(4'h4, r); check("drop_clear", r, 32'h0000_0100);
        rd(4'hC, r); check("reserved_read", r, 32'h0000_0000);

        // Foreign address held for a while
        @(posedge clk); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = BASE + 32'h10; wb.wbs_sel_i = 4'hF;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) acks++;
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        check("foreign_acks", 32'(acks), 32'h0);

        // Threshold 0 acts as 1
        wr(4'h8, 32'h0000_0003, 4'hF);
        spike(6'd7, 8'h55);
        check("thr0_lag", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("thr0_rise", 32'(irq), 32'h1);
        rd(4'h0, r); check("thr0_data", r, 32'h8000_5507);
        @(posedge clk); #1;
        check("thr0_fall", 32'(irq), 32'h0);

        // Byte selects
        wr(4'h8, 32'h0000_0800, 4'b0010);
        rd(4'h8, r); check("sel1_only", r, 32'h0000_0803);
        wr(4'h8, 32'h0000_1F00, 4'b0001);
        rd(4'h8, r); check("sel0_only", r, 32'h0000_0800);

        // Reset with data queued
        wr(4'h8, 32'h0000_0001, 4'hF);
        spike(6'd1, 8'h01);
        spike(6'd2, 8'h02);
        rd(4'h4, r); check("pre_reset_status", r, 32'h0000_0002);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd(4'h4, r); check("post_reset_status", r, 32'h0000_0100);
        rd(4'h8, r); check("post_reset_ctrl", r, 32'h0000_0000);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
